// File: rtl/hamming_secded_decoder.sv
// Pipelined Hamming SEC/SECDED decoder for the SSD-RAID read path.
// Stage 1 latches syndrome and overall parity, stage 2 corrects and registers.

module hamming_secded_decoder #(
    parameter  int DATA_W        = 8,
    parameter  int ENABLE_SECDED = 1,
    parameter  int CNT_W         = 16,
    localparam int PAR_W         = $clog2(DATA_W + $clog2(DATA_W) + 1),
    localparam int CW_W          = DATA_W + PAR_W + ENABLE_SECDED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_code,
    input  logic              bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int N = DATA_W + PAR_W;

    function automatic logic [PAR_W-1:0] calc_syn(input logic [N-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int pos = 1; pos <= N; pos++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (pos[k]) begin
                    s[k] = s[k] ^ cw[pos-1];
                end
            end
        end
        return s;
    endfunction

    // Data bits occupy every non-power-of-two position, LSB first.
    function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j = j + 1;
            end
        end
        return d;
    endfunction

    logic             s1_valid;
    logic [N-1:0]     s1_code;
    logic             s1_bypass;
    logic [PAR_W-1:0] s1_syn;
    logic             s1_op;

    logic adv1;
    logic adv2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_code   <= '0;
            s1_bypass <= 1'b0;
            s1_syn    <= '0;
            s1_op     <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code   <= in_code[N-1:0];
                s1_bypass <= bypass;
                s1_syn    <= calc_syn(in_code[N-1:0]);
                s1_op     <= (ENABLE_SECDED != 0) ? ^in_code : 1'b0;
            end
        end
    end

    logic [N-1:0] fixed;
    logic         single;
    logic         dbl;

    always_comb begin
        fixed  = s1_code;
        single = 1'b0;
        dbl    = 1'b0;
        if (!s1_bypass) begin
            // In SEC mode any nonzero syndrome is treated like op=1.
            if (s1_op || (ENABLE_SECDED == 0 && s1_syn != '0)) begin
                if (s1_syn == '0) begin
                    single = 1'b1;
                end else if (int'(s1_syn) <= N) begin
                    fixed  = s1_code ^ (N'(1) << (s1_syn - PAR_W'(1)));
                    single = 1'b1;
                end else begin
                    dbl = 1'b1;
                end
            end else if (s1_syn != '0) begin
                dbl = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
            out_syndrome   <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data       <= extract(fixed);
                out_err_single <= single;
                out_err_double <= dbl;
                out_syndrome   <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err_single && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (out_err_double && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
